mem_arbiter: RTL and testbench

//  Responder side of the cache_control_if request protocol: accepts i/d-cache requests from CPUS

---
 rtl/cpu_types_pkg.sv | 10 +
 rtl/mem_arbiter_if.sv | 17 +
 rtl/mem_arbiter_rr_picker.sv | 27 ++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/memory types plus the arbiter's source and state enums.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic {SRC_I, SRC_D} arb_src_t;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
    function automatic int cpu_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: per-CPU cache request lines and the single RAM port.
interface mem_arbiter_if #(parameter int CPUS = 2);
    import cpu_types_pkg::*;
    logic [CPUS-1:0]        iREN, dREN, dWEN, iwait, dwait;
    logic [CPUS-1:0][31:0]  iaddr, daddr, dstore, iload, dload;
    logic                   ramREN, ramWEN;
    word_t                  ramaddr, ramstore, ramload;
    ramstate_t              ramstate;
    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: round-robin pick starting at rr_ptr; dcache beats icache within a CPU.
module rr_picker import cpu_types_pkg::*; #(
    parameter int CPUS = 2,
    parameter int CW = cpu_w(CPUS)
) (
    input  logic [CPUS*2-1:0] req,
    input  logic [CW-1:0]     rr_ptr,
    output logic [CW-1:0]     gnt_cpu,
    output arb_src_t          gnt_src,
    output logic              gnt_valid
);
    // Scan lowest priority first so the highest-priority hit is the last assignment.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_cpu = '0;
        gnt_src = SRC_I;
        for (int k = CPUS - 1; k >= 0; k--) begin
            for (int s = 0; s < 2; s++) begin
                if (req[2 * ((int'(rr_ptr) + k) % CPUS) + s]) begin
                    gnt_valid = 1'b1;
                    gnt_cpu = CW'((int'(rr_ptr) + k) % CPUS);
                    gnt_src = s == 1 ? SRC_D : SRC_I;
                end
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one cache requester at a time onto the RAM, locking two-word dcache blocks.
// MEM_ARB_PERF_EN builds the completed-word and stall counters; otherwise they read 0.
module mem_arbiter import cpu_types_pkg::*; #(
    parameter int CPUS = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus,
    output word_t        perf_xact,
    output word_t        perf_stall
);
    localparam int CW = cpu_w(CPUS);
    arb_state_t state_q, state_d;
    arb_src_t src_q, src_d, pick_src;
    logic [CW-1:0] cpu_q, cpu_d, rr_ptr_q, rr_ptr_d, pick_cpu, nxt_cpu;
    logic [CPUS*2-1:0] req;
    logic pick_valid, is_d, live, wen, done;
    word_t addr;
    logic [CPUS-1:0] wait_i, wait_d;
    logic [CPUS-1:0][31:0] load_i, load_d;
    always_comb begin
        req = '0;
        for (int k = 0; k < CPUS; k++) begin
            req[2*k] = bus.iREN[k];
            req[2*k+1] = bus.dREN[k] | bus.dWEN[k];
        end
    end
    rr_picker #(.CPUS(CPUS), .CW(CW)) u_pick (
        .req(req), .rr_ptr(rr_ptr_q), .gnt_cpu(pick_cpu), .gnt_src(pick_src), .gnt_valid(pick_valid)
    );
    // RAM side follows the granted requester's live lines; a dropped request aborts the grant.
    always_comb begin
        is_d = src_q == SRC_D;
        live = state_q == ARB_GRANT && (is_d ? (bus.dREN[cpu_q] | bus.dWEN[cpu_q]) : bus.iREN[cpu_q]);
        wen = live && is_d && bus.dWEN[cpu_q];
        addr = is_d ? bus.daddr[cpu_q] : bus.iaddr[cpu_q];
        done = live && bus.ramstate == ACCESS;
        nxt_cpu = cpu_q == CW'(CPUS - 1) ? '0 : cpu_q + 1'b1;
    end
    assign bus.ramWEN = wen;
    assign bus.ramREN = live && !wen;
    assign bus.ramaddr = live ? addr : '0;
    assign bus.ramstore = wen ? bus.dstore[cpu_q] : '0;
    always_comb begin
        wait_i = '1;
        wait_d = '1;
        load_i = '0;
        load_d = '0;
        if (done && is_d) begin
            wait_d[cpu_q] = 1'b0;
            load_d[cpu_q] = bus.ramload;
        end
        if (done && !is_d) begin
            wait_i[cpu_q] = 1'b0;
            load_i[cpu_q] = bus.ramload;
        end
    end
    assign bus.iwait = wait_i;
    assign bus.dwait = wait_d;
    assign bus.iload = load_i;
    assign bus.dload = load_d;
    // A completed dcache word0 (addr[2]==0) keeps the grant so word1 cannot be interleaved.
    always_comb begin
        state_d = state_q;
        cpu_d = cpu_q;
        src_d = src_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == ARB_IDLE) begin
            if (pick_valid) begin
                state_d = ARB_GRANT;
                cpu_d = pick_cpu;
                src_d = pick_src;
            end
        end else if (!live || (done && !(is_d && !addr[2]))) begin
            state_d = ARB_IDLE;
            rr_ptr_d = nxt_cpu;
        end
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ARB_IDLE;
            cpu_q <= '0;
            src_q <= SRC_I;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            cpu_q <= cpu_d;
            src_q <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
`ifdef MEM_ARB_PERF_EN
    word_t xact_q, xact_d, stall_q, stall_d;
    always_comb begin
        xact_d = xact_q + 32'(done);
        stall_d = stall_q + 32'((|{bus.iREN, bus.dREN, bus.dWEN}) && !done);
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            xact_q <= '0;
            stall_q <= '0;
        end else begin
            xact_q <= xact_d;
            stall_q <= stall_d;
        end
    end
    assign perf_xact = xact_q;
    assign perf_stall = stall_q;
`else
    assign perf_xact = '0;
    assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level arbiter model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;
    localparam int CPUS = 2;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    word_t perf_xact, perf_stall;
    int total = 0;
    int bad = 0;
    mem_arbiter_if #(.CPUS(CPUS)) ifc();
    mem_arbiter #(.CPUS(CPUS)) dut (
        .CLK(CLK), .nRST(nRST), .bus(ifc), .perf_xact(perf_xact), .perf_stall(perf_stall)
    );
    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        ifc.iREN = '0; ifc.dREN = '0; ifc.dWEN = '0;
        ifc.iaddr = '0; ifc.daddr = '0; ifc.dstore = '0;
        ifc.ramload = '0; ifc.ramstate = FREE;
    endtask

    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        cyc(); cyc();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        #2;
        total++; if ({ifc.iwait, ifc.dwait} !== 4'b1111) begin bad++; $display("FAIL rst_waits got=%b exp=1111", {ifc.iwait, ifc.dwait}); end
        total++; if ({ifc.ramREN, ifc.ramWEN} !== 2'b00) begin bad++; $display("FAIL rst_en got=%b exp=00", {ifc.ramREN, ifc.ramWEN}); end
        total++; if ({ifc.ramaddr, ifc.ramstore} !== 64'h0) begin bad++; $display("FAIL rst_addr_store got=%h exp=0", {ifc.ramaddr, ifc.ramstore}); end
        total++; if ({ifc.iload, ifc.dload} !== '0) begin bad++; $display("FAIL rst_loads got=%h exp=0", {ifc.iload, ifc.dload}); end
        total++; if ({perf_xact, perf_stall} !== 64'h0) begin bad++; $display("FAIL rst_perf got=%h exp=0", {perf_xact, perf_stall}); end
        cyc();
        nRST = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        cyc(); ifc.dREN[0] = 1'b1; ifc.daddr[0] = 32'h100; ifc.ramstate = BUSY; #1;
        total++; if (ifc.ramREN !== 1'b0) begin bad++; $display("FAIL t1_idle_ren got=%b exp=0", ifc.ramREN); end
        cyc(); #1;
        total++; if ({ifc.ramREN, ifc.ramaddr} !== {1'b1, 32'h100}) begin bad++; $display("FAIL t1_grant got=%b/%h exp=1/100", ifc.ramREN, ifc.ramaddr); end
        cyc(); #1;
        total++; if (ifc.dwait !== 2'b11) begin bad++; $display("FAIL t1_busy_wait got=%b exp=11", ifc.dwait); end
        cyc(); ifc.ramstate = ACCESS; ifc.ramload = 32'hCAFE0001; #1;
        total++; if (ifc.dwait !== 2'b10) begin bad++; $display("FAIL t1_done_wait got=%b exp=10", ifc.dwait); end
        total++; if (ifc.dload[0] !== 32'hCAFE0001) begin bad++; $display("FAIL t1_dload got=%h exp=cafe0001", ifc.dload[0]); end
        cyc(); ifc.dREN = '0; ifc.ramstate = FREE; #1;
        total++; if (ifc.dwait !== 2'b11) begin bad++; $display("FAIL t1_one_cycle got=%b exp=11", ifc.dwait); end
    endtask

    task automatic test_burst();
        do_reset();
        cyc(); ifc.dREN[0] = 1'b1; ifc.daddr[0] = 32'h200; ifc.iREN[1] = 1'b1; ifc.iaddr[1] = 32'h300; ifc.ramstate = BUSY;
        cyc(); ifc.ramstate = ACCESS; ifc.ramload = 32'h11; #1;
        total++; if ({ifc.ramaddr, ifc.dwait, ifc.iwait} !== {32'h200, 2'b10, 2'b11}) begin bad++; $display("FAIL t2_word0 got=%h/%b/%b exp=200/10/11", ifc.ramaddr, ifc.dwait, ifc.iwait); end
        cyc(); ifc.daddr[0] = 32'h204; ifc.ramload = 32'h22; #1;
        total++; if ({ifc.ramaddr, ifc.dwait, ifc.iwait} !== {32'h204, 2'b10, 2'b11}) begin bad++; $display("FAIL t2_word1 got=%h/%b/%b exp=204/10/11", ifc.ramaddr, ifc.dwait, ifc.iwait); end
        cyc(); ifc.dREN = '0; ifc.ramstate = BUSY; #1;
        total++; if (ifc.ramREN !== 1'b0) begin bad++; $display("FAIL t2_idle got=%b exp=0", ifc.ramREN); end
        cyc(); ifc.ramstate = ACCESS; #1;
        total++; if ({ifc.ramaddr, ifc.iwait} !== {32'h300, 2'b01}) begin bad++; $display("FAIL t2_cpu1 got=%h/%b exp=300/01", ifc.ramaddr, ifc.iwait); end
    endtask

    task automatic test_alternate();
        int seen = 0;
        do_reset();
        cyc(); ifc.iREN = 2'b11; ifc.iaddr[0] = 32'h10; ifc.iaddr[1] = 32'h20; ifc.ramstate = ACCESS;
        for (int n = 0; n < 20 && seen < 4; n++) begin
            #1;
            total++; if ($countones(~{ifc.iwait, ifc.dwait}) > 1) begin bad++; $display("FAIL t3_onehot got=%b exp=at_most_one_low", {ifc.iwait, ifc.dwait}); end
            if (ifc.iwait != 2'b11) begin
                total++; if (ifc.iwait !== (seen % 2 == 0 ? 2'b10 : 2'b01)) begin bad++; $display("FAIL t3_order got=%b exp_cpu=%0d", ifc.iwait, seen % 2); end
                seen++;
            end
            cyc();
        end
        total++; if (seen != 4) begin bad++; $display("FAIL t3_count got=%0d exp=4", seen); end
    endtask

    task automatic test_write();
        do_reset();
        cyc(); ifc.dWEN[1] = 1'b1; ifc.daddr[1] = 32'h40; ifc.dstore[1] = 32'hDEADBEEF; ifc.iREN[1] = 1'b1; ifc.iaddr[1] = 32'h80; ifc.ramstate = BUSY;
        cyc(); #1;
        total++; if ({ifc.ramWEN, ifc.ramREN, ifc.ramaddr, ifc.ramstore} !== {2'b10, 32'h40, 32'hDEADBEEF}) begin bad++; $display("FAIL t4_write got=%b%b/%h/%h exp=10/40/deadbeef", ifc.ramWEN, ifc.ramREN, ifc.ramaddr, ifc.ramstore); end
        cyc(); ifc.ramstate = ACCESS; #1;
        total++; if ({ifc.dwait, ifc.iwait} !== 4'b0111) begin bad++; $display("FAIL t4_done got=%b exp=0111", {ifc.dwait, ifc.iwait}); end
        cyc(); ifc.dWEN = '0; ifc.ramstate = BUSY; #1;
        total++; if ({ifc.iwait, ifc.ramWEN} !== 3'b110) begin bad++; $display("FAIL t4_abort got=%b exp=110", {ifc.iwait, ifc.ramWEN}); end
        cyc(); ifc.ramstate = ACCESS; #1;
        total++; if (ifc.iwait !== 2'b11) begin bad++; $display("FAIL t4_idle_iwait got=%b exp=11", ifc.iwait); end
        cyc(); #1;
        total++; if ({ifc.ramaddr, ifc.iwait} !== {32'h80, 2'b01}) begin bad++; $display("FAIL t4_ifetch got=%h/%b exp=80/01", ifc.ramaddr, ifc.iwait); end
    endtask

    task automatic test_abort();
        do_reset();
        cyc(); ifc.dREN[0] = 1'b1; ifc.daddr[0] = 32'h100; ifc.ramstate = BUSY;
        cyc(); #1;
        total++; if (ifc.ramREN !== 1'b1) begin bad++; $display("FAIL t5_grant got=%b exp=1", ifc.ramREN); end
        cyc(); ifc.dREN = '0; #1;
        total++; if (ifc.ramREN !== 1'b0) begin bad++; $display("FAIL t5_drop got=%b exp=0", ifc.ramREN); end
        cyc(); ifc.iREN = 2'b11; ifc.iaddr[0] = 32'h500; ifc.iaddr[1] = 32'h600; ifc.ramstate = ACCESS; #1;
        total++; if ({ifc.ramREN, ifc.iwait} !== 3'b011) begin bad++; $display("FAIL t5_idle got=%b exp=011", {ifc.ramREN, ifc.iwait}); end
        cyc(); #1;
        total++; if ({ifc.ramaddr, ifc.iwait} !== {32'h600, 2'b01}) begin bad++; $display("FAIL t5_rr got=%h/%b exp=600/01", ifc.ramaddr, ifc.iwait); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(); ifc.iREN[0] = 1'b1; ifc.iaddr[0] = 32'h30; ifc.ramstate = BUSY;
        cyc(); #1;
        total++; if (ifc.ramREN !== 1'b1) begin bad++; $display("FAIL t6_grant got=%b exp=1", ifc.ramREN); end
        #1; nRST = 1'b0; #1;
        total++; if ({ifc.ramREN, ifc.ramWEN, ifc.ramaddr} !== 34'h0) begin bad++; $display("FAIL t6_ram got=%b%b/%h exp=00/0", ifc.ramREN, ifc.ramWEN, ifc.ramaddr); end
        total++; if ({ifc.iwait, ifc.dwait} !== 4'b1111) begin bad++; $display("FAIL t6_waits got=%b exp=1111", {ifc.iwait, ifc.dwait}); end
        total++; if ({perf_xact, perf_stall} !== 64'h0) begin bad++; $display("FAIL t6_perf got=%h exp=0", {perf_xact, perf_stall}); end
        idle_inputs();
        cyc();
        nRST = 1'b1;
    endtask

    task automatic test_random();
        bit i_act[CPUS], d_act[CPUS], d_wen[CPUS];
        word_t i_a[CPUS], d_a[CPUS], d_s[CPUS];
        int d_left[CPUS];
        bit busy = 0, wd = 0, fin_d = 0, any, exp_done, exp_we;
        int w = 0, rr = 0, fin_c = -1, n_x = 0, n_s = 0;
        word_t exp_a, got_l;
        logic [CPUS-1:0] exp_iw, exp_dw;
        for (int c = 0; c < CPUS; c++) begin i_act[c] = 0; d_act[c] = 0; d_wen[c] = 0; d_left[c] = 0; end
        do_reset();
        repeat (400) begin
            cyc();
            if (fin_c >= 0) begin
                if (!fin_d) i_act[fin_c] = 0;
                else if (d_left[fin_c] == 2) begin d_left[fin_c] = 1; d_a[fin_c] += 4; d_s[fin_c] = $urandom; end
                else d_act[fin_c] = 0;
                fin_c = -1;
            end
            for (int c = 0; c < CPUS; c++) begin
                if (!i_act[c] && $urandom_range(0, 3) == 0) begin i_act[c] = 1; i_a[c] = $urandom & ~32'h3; end
                if (!d_act[c] && $urandom_range(0, 3) == 0) begin
                    d_act[c] = 1; d_a[c] = $urandom & ~32'h7; d_wen[c] = 1'($urandom_range(0, 1)); d_s[c] = $urandom; d_left[c] = 2;
                end
                ifc.iREN[c] = i_act[c]; ifc.iaddr[c] = i_a[c];
                ifc.dWEN[c] = d_act[c] && d_wen[c];
                ifc.dREN[c] = d_act[c] && (!d_wen[c] || $urandom_range(0, 1) == 1);
                ifc.daddr[c] = d_a[c]; ifc.dstore[c] = d_s[c];
            end
            case ($urandom_range(0, 3))
                0: ifc.ramstate = BUSY;
                1: ifc.ramstate = ERROR;
                default: ifc.ramstate = ACCESS;
            endcase
            ifc.ramload = $urandom;
            #1;
            any = 0;
            for (int c = 0; c < CPUS; c++) any |= i_act[c] | d_act[c];
            total++; if ($countones(~{ifc.iwait, ifc.dwait}) > 1) begin bad++; $display("FAIL rnd_onehot got=%b exp=at_most_one_low", {ifc.iwait, ifc.dwait}); end
            if (busy) begin
                exp_a = wd ? d_a[w] : i_a[w];
                exp_we = wd && d_wen[w];
                exp_done = ifc.ramstate == ACCESS;
                exp_iw = '1; exp_dw = '1;
                if (exp_done) begin if (wd) exp_dw[w] = 1'b0; else exp_iw[w] = 1'b0; end
                total++; if ({ifc.ramaddr, ifc.ramWEN, ifc.ramREN} !== {exp_a, exp_we, !exp_we}) begin bad++; $display("FAIL rnd_ram got=%h/%b%b exp=%h/%b%b", ifc.ramaddr, ifc.ramWEN, ifc.ramREN, exp_a, exp_we, !exp_we); end
                if (exp_we) begin total++; if (ifc.ramstore !== d_s[w]) begin bad++; $display("FAIL rnd_store got=%h exp=%h", ifc.ramstore, d_s[w]); end end
                total++; if ({ifc.iwait, ifc.dwait} !== {exp_iw, exp_dw}) begin bad++; $display("FAIL rnd_waits got=%b exp=%b", {ifc.iwait, ifc.dwait}, {exp_iw, exp_dw}); end
                if (exp_done) begin
                    got_l = wd ? ifc.dload[w] : ifc.iload[w];
                    total++; if (got_l !== ifc.ramload) begin bad++; $display("FAIL rnd_load got=%h exp=%h", got_l, ifc.ramload); end
                    fin_c = w; fin_d = wd; n_x++;
                    if (!(wd && d_left[w] == 2)) begin busy = 0; rr = (w + 1) % CPUS; end
                end else if (any) n_s++;
            end else begin
                total++; if ({ifc.iwait, ifc.dwait, ifc.ramREN, ifc.ramWEN} !== 6'b111100) begin bad++; $display("FAIL rnd_idle got=%b exp=111100", {ifc.iwait, ifc.dwait, ifc.ramREN, ifc.ramWEN}); end
                if (any) n_s++;
                for (int k = 0; k < CPUS && !busy; k++) begin
                    if (d_act[(rr + k) % CPUS]) begin busy = 1; w = (rr + k) % CPUS; wd = 1; end
                    else if (i_act[(rr + k) % CPUS]) begin busy = 1; w = (rr + k) % CPUS; wd = 0; end
                end
            end
        end
        cyc(); idle_inputs(); #1;
`ifdef MEM_ARB_PERF_EN
        total++; if ({perf_xact, perf_stall} !== {32'(n_x), 32'(n_s)}) begin bad++; $display("FAIL rnd_perf got=%0d/%0d exp=%0d/%0d", perf_xact, perf_stall, n_x, n_s); end
`else
        total++; if ({perf_xact, perf_stall} !== 64'h0) begin bad++; $display("FAIL rnd_perf got=%0d/%0d exp=0/0 (n_x=%0d)", perf_xact, perf_stall, n_x); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_alternate();
        test_write();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
